// File: rtl/fht_defines.sv
// Shared defaults and FSM state encoding for the FHT streaming front/back end.
package fht_defines;

    localparam int DEF_IN_BIT = 16;
    localparam int DEF_D_BIT  = 18;
    localparam int DEF_A_BIT  = 8;
    localparam int DEF_N_BANK = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_CALC   = 3'd3,
        ST_UNLOAD = 3'd4
    } fht_state_t;

endpackage

// File: rtl/fht_skid_buf.sv
// Two-entry output skid buffer: registered output, ready depends only on fill level,
// so a steady one-entry occupancy sustains one transfer per cycle.
module fht_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   count;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push;
    logic         pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (count)
                2'd0: if (push) begin
                    head  <= in_data;
                    count <= 2'd1;
                end
                2'd1: if (push && pop) begin
                    head <= in_data;
                end else if (push) begin
                    tail  <= in_data;
                    count <= 2'd2;
                end else if (pop) begin
                    count <= 2'd0;
                end
                2'd2: if (pop) begin
                    head  <= tail;
                    count <= 2'd1;
                end
                default: count <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/fht_stream_top.sv
// Streams one frame of ADC samples into the banked FHT core RAM, starts the core,
// then drains the result in natural order through a skid buffer.
//
//   state  | meaning
//   IDLE   | waiting for the first sample of a frame (written as point 0)
//   LOAD   | accepting points 1..N_PT-1 into the banks
//   START  | one-cycle start strobe to the core
//   CALC   | waiting for the core completion strobe
//   UNLOAD | reading rows back and emitting points 0..N_PT-1
module fht_stream_top
    import fht_defines::*;
#(
    parameter int IN_BIT    = DEF_IN_BIT,
    parameter int D_BIT     = DEF_D_BIT,
    parameter int A_BIT     = DEF_A_BIT,
    parameter int N_BANK    = DEF_N_BANK,
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iS_VALID,
    input  logic [IN_BIT-1:0]       iS_DATA,
    output logic                    oS_READY,
    output logic                    oM_VALID,
    output logic [D_BIT-1:0]        oM_DATA,
    output logic                    oM_LAST,
    input  logic                    iM_READY,
    output logic [D_BIT-1:0]        oCORE_DATA,
    output logic [A_BIT-1:0]        oCORE_ADDR_WR,
    output logic [N_BANK-1:0]       oCORE_WE,
    output logic                    oCORE_START,
    input  logic                    iCORE_RDY,
    output logic [A_BIT-1:0]        oCORE_ADDR_RD,
    input  logic [N_BANK*D_BIT-1:0] iCORE_DATA,
    output logic                    oBUSY,
    output logic [15:0]             oFRAME_CNT
);

    localparam int B_BIT = $clog2(N_BANK);
    localparam int P_BIT = A_BIT + B_BIT;
    localparam logic [P_BIT-1:0]  P_LAST   = '1;
    localparam logic [A_BIT-1:0]  ROW_LAST = '1;
    localparam logic [B_BIT-1:0]  COL_LAST = B_BIT'(N_BANK - 1);
    localparam logic [N_BANK-1:0] WE_ONE   = N_BANK'(1);

    fht_state_t       state;
    fht_state_t       state_nxt;
    logic [P_BIT-1:0] wr_cnt;
    logic             accept;
    logic [15:0]      frame_cnt;

    logic [A_BIT-1:0] rd_addr;
    logic             bus_valid;
    logic             fetch_done;
    logic             row_valid;
    logic [D_BIT-1:0] row_buf [N_BANK];
    logic [B_BIT-1:0] col;
    logic             sb_ready;
    logic             push;
    logic             push_last;
    logic             load_row;
    logic             out_last_hs;
    logic [D_BIT:0]   sb_out;

    assign oS_READY   = (state == ST_IDLE) || (state == ST_LOAD);
    assign accept     = iS_VALID && oS_READY;
    assign oCORE_DATA = SIGNED_IN ? {{(D_BIT-IN_BIT){iS_DATA[IN_BIT-1]}}, iS_DATA}
                                  : {{(D_BIT-IN_BIT){1'b0}}, iS_DATA};
    assign oCORE_ADDR_WR = wr_cnt[P_BIT-1:B_BIT];
    assign oCORE_WE      = accept ? (WE_ONE << wr_cnt[B_BIT-1:0]) : '0;
    assign oCORE_ADDR_RD = rd_addr;
    assign oBUSY         = (state != ST_IDLE);
    assign oFRAME_CNT    = frame_cnt;

    // A whole row is latched so the next row address can be issued while it drains.
    assign push        = row_valid && sb_ready;
    assign push_last   = fetch_done && (col == COL_LAST);
    assign load_row    = bus_valid && (!row_valid || (push && col == COL_LAST));
    assign out_last_hs = oM_VALID && iM_READY && oM_LAST;

    always_comb begin
        state_nxt   = state;
        oCORE_START = 1'b0;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_LOAD;
            ST_LOAD:   if (accept && wr_cnt == P_LAST) state_nxt = ST_START;
            ST_START: begin
                oCORE_START = 1'b1;
                state_nxt   = ST_CALC;
            end
            ST_CALC:   if (iCORE_RDY) state_nxt = ST_UNLOAD;
            ST_UNLOAD: if (out_last_hs) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state      <= ST_IDLE;
            wr_cnt     <= '0;
            frame_cnt  <= '0;
            rd_addr    <= '0;
            bus_valid  <= 1'b0;
            fetch_done <= 1'b0;
            row_valid  <= 1'b0;
            col        <= '0;
            for (int k = 0; k < N_BANK; k++) row_buf[k] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) wr_cnt <= wr_cnt + 1'b1;
            if (out_last_hs) frame_cnt <= frame_cnt + 16'd1;

            if (state != ST_UNLOAD) begin
                rd_addr    <= '0;
                fetch_done <= 1'b0;
                row_valid  <= 1'b0;
                col        <= '0;
                // Row 0 is read on the completion edge, so it is ready on UNLOAD entry.
                bus_valid  <= (state == ST_CALC) && iCORE_RDY;
            end else begin
                if (push) col <= col + 1'b1;
                if (load_row) begin
                    for (int k = 0; k < N_BANK; k++) row_buf[k] <= iCORE_DATA[k*D_BIT +: D_BIT];
                    row_valid <= 1'b1;
                    bus_valid <= 1'b0;
                    if (rd_addr == ROW_LAST) fetch_done <= 1'b1;
                    else                     rd_addr    <= rd_addr + 1'b1;
                end else begin
                    if (push && col == COL_LAST) row_valid <= 1'b0;
                    bus_valid <= !fetch_done;
                end
            end
        end
    end

    fht_skid_buf #(.W(D_BIT + 1)) u_skid (
        .clk       (iCLK),
        .rst_n     (iRESET),
        .in_valid  (row_valid),
        .in_ready  (sb_ready),
        .in_data   ({push_last, row_buf[col]}),
        .out_valid (oM_VALID),
        .out_ready (iM_READY),
        .out_data  (sb_out)
    );

    assign oM_LAST = sb_out[D_BIT];
    assign oM_DATA = sb_out[D_BIT-1:0];

endmodule

// File: tb/tb_fht_stream_top.sv
// Randomized frame-level bench for fht_stream_top with a behavioural core RAM model.
module tb_fht_stream_top;

    localparam int IN_BIT = 16;
    localparam int D_BIT  = 18;
    localparam int A_BIT  = 2;
    localparam int N_BANK = 4;
    localparam int N_ROW  = 1 << A_BIT;
    localparam int N_PT   = N_BANK * N_ROW;

    logic clk = 1'b0;
    logic rst_n;
    logic s_valid, m_ready, core_rdy;
    logic [IN_BIT-1:0] s_data;
    logic s_ready, m_valid, m_last, core_start, busy;
    logic [D_BIT-1:0] m_data, core_wdata, core_wdata_u;
    logic [A_BIT-1:0] addr_wr, addr_rd;
    logic [N_BANK-1:0] core_we;
    logic [N_BANK*D_BIT-1:0] core_rdata;
    logic [15:0] frame_cnt;

    logic u_s_ready, u_m_valid, u_m_last, u_start, u_busy;
    logic [D_BIT-1:0] u_m_data;
    logic [A_BIT-1:0] u_addr_wr, u_addr_rd;
    logic [N_BANK-1:0] u_we;
    logic [15:0] u_frame;

    logic [D_BIT-1:0]  result [N_BANK][N_ROW];
    logic [IN_BIT-1:0] samples [N_PT];
    int n_tests = 0;
    int n_fail  = 0;
    int exp_frames = 0;
    bit ab;

    always #5 clk = ~clk;

    fht_stream_top #(.IN_BIT(IN_BIT), .D_BIT(D_BIT), .A_BIT(A_BIT), .N_BANK(N_BANK), .SIGNED_IN(1'b1)) dut (
        .iCLK(clk), .iRESET(rst_n), .iS_VALID(s_valid), .iS_DATA(s_data), .oS_READY(s_ready),
        .oM_VALID(m_valid), .oM_DATA(m_data), .oM_LAST(m_last), .iM_READY(m_ready),
        .oCORE_DATA(core_wdata), .oCORE_ADDR_WR(addr_wr), .oCORE_WE(core_we),
        .oCORE_START(core_start), .iCORE_RDY(core_rdy), .oCORE_ADDR_RD(addr_rd),
        .iCORE_DATA(core_rdata), .oBUSY(busy), .oFRAME_CNT(frame_cnt)
    );

    fht_stream_top #(.IN_BIT(IN_BIT), .D_BIT(D_BIT), .A_BIT(A_BIT), .N_BANK(N_BANK), .SIGNED_IN(1'b0)) dut_u (
        .iCLK(clk), .iRESET(rst_n), .iS_VALID(s_valid), .iS_DATA(s_data), .oS_READY(u_s_ready),
        .oM_VALID(u_m_valid), .oM_DATA(u_m_data), .oM_LAST(u_m_last), .iM_READY(m_ready),
        .oCORE_DATA(core_wdata_u), .oCORE_ADDR_WR(u_addr_wr), .oCORE_WE(u_we),
        .oCORE_START(u_start), .iCORE_RDY(core_rdy), .oCORE_ADDR_RD(u_addr_rd),
        .iCORE_DATA(core_rdata), .oBUSY(u_busy), .oFRAME_CNT(u_frame)
    );

    // Core result RAM: one-cycle registered read, all banks share the address.
    always @(posedge clk)
        for (int k = 0; k < N_BANK; k++) core_rdata[k*D_BIT +: D_BIT] <= result[k][addr_rd];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ext(input logic [IN_BIT-1:0] s, input bit sgn);
        int v;
        v = int'(s);
        if (sgn && v >= (1 << (IN_BIT - 1))) v = v - (1 << IN_BIT);
        return 32'(v & ((1 << D_BIT) - 1));
    endfunction

    task automatic new_samples();
        for (int p = 0; p < N_PT; p++) samples[p] = 16'($urandom);
    endtask

    task automatic set_results(input bit fixed);
        for (int k = 0; k < N_BANK; k++)
            for (int a = 0; a < N_ROW; a++)
                result[k][a] = fixed ? D_BIT'(100 * k + a) : D_BIT'($urandom);
    endtask

    task automatic load_frame(input bit gaps, input bit rdy_glitch, input int abort_at, output bit aborted);
        int p = 0;
        int cyc = 0;
        aborted = 1'b0;
        while (p < N_PT && cyc < 400) begin
            @(negedge clk);
            s_valid  = gaps ? (1'($urandom_range(0, 2)) != 1'b0) : 1'b1;
            s_data   = samples[p];
            core_rdy = rdy_glitch && (cyc == 3 || cyc == 9);
            if (p == abort_at && s_valid) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1; s_valid = 1'b0; core_rdy = 1'b0;
                exp_frames = 0;
                aborted = 1'b1;
                return;
            end
            #1;
            check_val("s_ready_load", s_ready, 1);
            if (s_valid) begin
                check_val("we", core_we, 32'(1 << (p % N_BANK)));
                check_val("addr_wr", addr_wr, p / N_BANK);
                check_val("core_data_s", core_wdata, ext(samples[p], 1'b1));
                check_val("core_data_u", core_wdata_u, ext(samples[p], 1'b0));
                if (p == 0 && samples[0] == 16'h8000) begin
                    check_val("ext_8000_s", core_wdata, 32'h38000);
                    check_val("ext_8000_u", core_wdata_u, 32'h08000);
                end
                p++;
            end else begin
                check_val("we_gap", core_we, 0);
            end
            cyc++;
        end
        if (p < N_PT) check_val("load_timeout", p, N_PT);
        @(negedge clk);
        s_valid = 1'b1; core_rdy = 1'b0;
        #1;
        check_val("start_pulse", core_start, 1);
        check_val("s_ready_start", s_ready, 0);
        check_val("we_start", core_we, 0);
        check_val("busy_start", busy, 1);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        check_val("start_once", core_start, 0);
        check_val("s_ready_calc", s_ready, 0);
    endtask

    task automatic calc_unload(input bit rand_ready);
        int q = 0;
        int cyc = 0;
        int first = -1;
        int last_hs = 0;
        bit prev_stall = 1'b0;
        logic [D_BIT-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        repeat ($urandom_range(1, 5)) begin
            @(negedge clk); #1;
            check_val("m_valid_calc", m_valid, 0);
        end
        @(negedge clk); core_rdy = 1'b1;
        @(negedge clk); core_rdy = 1'b0;
        while (q < N_PT && cyc < 500) begin
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall) begin
                check_val("stall_valid", m_valid, 1);
                check_val("stall_data", m_data, prev_data);
                check_val("stall_last", m_last, prev_last);
            end
            if (m_valid && first < 0) begin
                first = cyc;
                check_val("latency_le3", 32'(cyc <= 2), 1);
            end
            if (m_valid && m_ready) begin
                check_val("m_data", m_data, result[q % N_BANK][q / N_BANK]);
                check_val("m_last", m_last, 32'(q == N_PT - 1));
                last_hs = cyc;
                q++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            cyc++;
            @(negedge clk);
        end
        if (q < N_PT) check_val("unload_timeout", q, N_PT);
        if (!rand_ready) check_val("back_to_back", last_hs - first + 1, N_PT);
        exp_frames++;
        m_ready = 1'b1;
        #1;
        check_val("m_valid_after", m_valid, 0);
        check_val("busy_after", busy, 0);
        check_val("s_ready_after", s_ready, 1);
        check_val("frame_cnt", frame_cnt, exp_frames);
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; core_rdy = 1'b0;
        set_results(1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_m_last", m_last, 0);
        check_val("rst_we", core_we, 0);
        check_val("rst_start", core_start, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_frame", frame_cnt, 0);
        check_val("rst_s_ready", s_ready, 1);

        new_samples(); samples[0] = 16'h8000; samples[1] = 16'h7fff;
        set_results(1'b1);
        load_frame(1'b0, 1'b0, -1, ab);
        calc_unload(1'b0);

        new_samples(); set_results(1'b0);
        load_frame(1'b1, 1'b1, -1, ab);
        calc_unload(1'b1);

        new_samples();
        load_frame(1'b0, 1'b0, 7, ab);
        check_val("aborted", ab, 1);
        repeat (4) begin
            #1;
            check_val("abort_start", core_start, 0);
            check_val("abort_m_valid", m_valid, 0);
            check_val("abort_busy", busy, 0);
            check_val("abort_frame", frame_cnt, 0);
            @(negedge clk);
        end

        new_samples(); set_results(1'b0);
        load_frame(1'b0, 1'b0, -1, ab);
        calc_unload(1'b1);

        new_samples(); set_results(1'b0);
        load_frame(1'b1, 1'b0, -1, ab);
        calc_unload(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fht_stream_top.md
FHT_STREAM_TOP -- requirements
Module: fht_stream_top

Interface
REQ-001 Parameter IN_BIT, default 16: width of the raw ADC sample.
REQ-002 Parameter D_BIT, default 18: width of the core data word; SHALL be greater than IN_BIT.
REQ-003 Parameter A_BIT, default 8: per-bank address width.
REQ-004 Parameter N_BANK, default 4: bank count; SHALL be a power of two in {2, 4, 8}.
REQ-005 Parameter SIGNED_IN, default 1: 1 = sign-extend input samples, 0 = zero-extend.
REQ-006 Derived constant N_PT = N_BANK * 2^A_BIT: points per frame.
REQ-007 The block SHALL use one clock and a synchronous, active-low reset, with ports named as listed below.
REQ-008 iCLK  in  1  clock.
REQ-009 iRESET  in  1  synchronous active-low reset.
REQ-010 iS_VALID  in  1  input sample valid.
REQ-011 iS_DATA  in  IN_BIT  input sample.
REQ-012 oS_READY  out  1  block accepts an input sample.
REQ-013 oM_VALID  out  1  output point valid.
REQ-014 oM_DATA  out  D_BIT  output point, signed.
REQ-015 oM_LAST  out  1  marks the last point of a frame.
REQ-016 iM_READY  in  1  downstream accepts an output point.
REQ-017 oCORE_DATA  out  D_BIT  extended sample to the core RAM(A).
REQ-018 oCORE_ADDR_WR  out  A_BIT  core write address.
REQ-019 oCORE_WE  out  N_BANK  one-hot bank write enable.
REQ-020 oCORE_START  out  1  one-cycle start strobe to the core.
REQ-021 iCORE_RDY  in  1  one-cycle completion strobe from the core.
REQ-022 oCORE_ADDR_RD  out  A_BIT  core read address, shared by all banks.
REQ-023 iCORE_DATA  in  N_BANK*D_BIT  core bank outputs; bank k occupies bits [k*D_BIT +: D_BIT].
REQ-024 oBUSY  out  1  high in any state other than IDLE.
REQ-025 oFRAME_CNT  out  16  count of completed frames; wraps at 2^16.

Function
REQ-026 The FSM SHALL have states IDLE, LOAD, START, CALC and UNLOAD.
REQ-027 IDLE SHALL go to LOAD on the first accepted sample, and that sample SHALL be written as point 0.
REQ-028 oS_READY SHALL be 1 only in IDLE and LOAD; a sample is accepted when iS_VALID and oS_READY are both 1.
REQ-029 Accepted point p SHALL be written to bank (p mod N_BANK) at address (p / N_BANK) in the same cycle: oCORE_WE one-hot, oCORE_ADDR_WR and oCORE_DATA combinational.
REQ-030 oCORE_DATA SHALL be iS_DATA extended to D_BIT bits according to SIGNED_IN.
REQ-031 When point N_PT-1 is accepted, the FSM SHALL go to START; oS_READY SHALL be 0 from the next cycle.
REQ-032 START SHALL assert oCORE_START for exactly one cycle, then go to CALC.
REQ-033 CALC SHALL wait for iCORE_RDY, then go to UNLOAD; iCORE_RDY outside CALC SHALL be ignored.
REQ-034 UNLOAD SHALL emit points 0..N_PT-1 in natural order: point q is read from bank (q mod N_BANK) at address (q / N_BANK).
REQ-035 Core read latency is 1 cycle; the read address SHALL advance to the next bank-row once all N_BANK words of the current row are consumed.
REQ-036 A 2-entry output skid buffer SHALL make the output full-throughput under backpressure: one point per cycle while iM_READY is held 1.
REQ-037 oM_DATA and oM_LAST SHALL hold stable while oM_VALID=1 and iM_READY=0.
REQ-038 oM_LAST SHALL be 1 with point N_PT-1 only.
REQ-039 On the handshake of the last point, the FSM SHALL go to IDLE and oFRAME_CNT SHALL increment.
REQ-040 Latency: first oM_VALID SHALL occur at most 3 cycles after the iCORE_RDY strobe.
REQ-041 Simultaneous sample acceptance and FSM transition in the same cycle SHALL lose no sample.

Reset
REQ-042 On iRESET=0 at a clock edge: FSM to IDLE, all counters and the skid buffer cleared.
REQ-043 Reset values: oM_VALID=0, oM_LAST=0, oCORE_WE=0, oCORE_START=0, oBUSY=0, oFRAME_CNT=0, oS_READY=1 from the first cycle after reset release.
REQ-044 Reset mid-frame (any state) SHALL abandon the frame, with no oCORE_START and no partial output afterwards.

Structure
REQ-045 Shared package fht_defines SHALL hold the default IN_BIT, D_BIT, A_BIT and N_BANK values and the FSM state encoding.
REQ-046 The output skid buffer SHALL be a sub-module, fht_skid_buf, parameterised by width.

Verification
REQ-047 N_BANK=4, A_BIT=2, stream points 0..15 with iS_VALID=1 continuously -> banks 0..3 written with bank = p mod 4, addr = p/4; one oCORE_START pulse the cycle after point 15.
REQ-048 Sample 16'h8000 with SIGNED_IN=1 -> oCORE_DATA=18'h38000; with SIGNED_IN=0 -> 18'h08000.
REQ-049 Core model returns word = 100*bank + addr, iM_READY=1 -> 16 outputs in natural order on consecutive cycles, oM_LAST on the 16th, oFRAME_CNT=1.
REQ-050 iM_READY toggled randomly, 50% -> no loss or duplication, data stable while stalled.
REQ-051 iCORE_RDY pulsed during LOAD -> ignored; frame completes normally.
REQ-052 Reset at point 7 of LOAD, then a full frame -> that frame loads from point 0 and output is correct; oFRAME_CNT=1.
